// File: rtl/eth_axil_pkg.sv
// Shared AXI4-Lite initiator definitions: FSM state encoding and AXI response codes.
package eth_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/eth_axil_fifo_initiator.sv
// Single-outstanding AXI4-Lite master: valid/ready request in, AXI transaction, response out.
// Minimum 3 cycles accept-to-response; new requests are held off until the response is consumed.
module eth_axil_fifo_initiator
    import eth_axil_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int axil_mask_width_lp = axil_data_width_p >> 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [axil_addr_width_p-1:0]  addr_i,
    input  logic [axil_data_width_p-1:0]  data_i,
    input  logic                          w_i,
    input  logic [axil_mask_width_lp-1:0] wmask_i,
    input  logic                          v_i,
    output logic                          ready_and_o,

    output logic [axil_data_width_p-1:0]  data_o,
    output logic                          err_o,
    output logic                          v_o,
    input  logic                          ready_and_i,

    output logic [axil_addr_width_p-1:0]  m_axil_awaddr_o,
    output logic [2:0]                    m_axil_awprot_o,
    output logic                          m_axil_awvalid_o,
    input  logic                          m_axil_awready_i,

    output logic [axil_data_width_p-1:0]  m_axil_wdata_o,
    output logic [axil_mask_width_lp-1:0] m_axil_wstrb_o,
    output logic                          m_axil_wvalid_o,
    input  logic                          m_axil_wready_i,

    input  logic [1:0]                    m_axil_bresp_i,
    input  logic                          m_axil_bvalid_i,
    output logic                          m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]  m_axil_araddr_o,
    output logic [2:0]                    m_axil_arprot_o,
    output logic                          m_axil_arvalid_o,
    input  logic                          m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]  m_axil_rdata_i,
    input  logic [1:0]                    m_axil_rresp_i,
    input  logic                          m_axil_rvalid_i,
    output logic                          m_axil_rready_o
);

    state_e                          state_q, state_d;
    logic [axil_addr_width_p-1:0]    addr_q, addr_d;
    logic [axil_data_width_p-1:0]    data_q, data_d;
    logic [axil_mask_width_lp-1:0]   wmask_q, wmask_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [axil_data_width_p-1:0]    resp_data_q, resp_data_d;
    logic                            err_q, err_d;

    logic aw_fire, w_fire;

    // Gating with reset_i keeps the request side closed for every reset cycle.
    assign ready_and_o      = (state_q == ST_IDLE) && !reset_i;

    assign m_axil_awaddr_o  = addr_q;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = (state_q == ST_WRITE) && !aw_done_q;
    assign m_axil_wdata_o   = data_q;
    assign m_axil_wstrb_o   = wmask_q;
    assign m_axil_wvalid_o  = (state_q == ST_WRITE) && !w_done_q;
    assign m_axil_bready_o  = (state_q == ST_WRESP);
    assign m_axil_araddr_o  = addr_q;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = (state_q == ST_READ);
    assign m_axil_rready_o  = (state_q == ST_RDATA);

    assign v_o    = (state_q == ST_RESP);
    assign data_o = resp_data_q;
    assign err_o  = err_q;

    assign aw_fire = m_axil_awvalid_o && m_axil_awready_i;
    assign w_fire  = m_axil_wvalid_o && m_axil_wready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wmask_d     = wmask_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (v_i && ready_and_o) begin
                    addr_d    = addr_i;
                    data_d    = data_i;
                    wmask_d   = wmask_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = w_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, possibly in the same cycle.
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_axil_bvalid_i) begin
                    resp_data_d = '0;
                    err_d       = resp_is_err(m_axil_bresp_i);
                    state_d     = ST_RESP;
                end
            end
            ST_READ: begin
                if (m_axil_arready_i) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (m_axil_rvalid_i) begin
                    resp_data_d = m_axil_rdata_i;
                    err_d       = resp_is_err(m_axil_rresp_i);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ready_and_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wmask_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wmask_q     <= wmask_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_eth_axil_fifo_initiator.sv
// Bench for eth_axil_fifo_initiator: directed and randomized transactions checked against a cycle-timeline model.
module tb_eth_axil_fifo_initiator;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = DW >> 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic          w_i;
    logic [MW-1:0] wmask_i;
    logic          v_i;
    logic          ready_and_o;
    logic [DW-1:0] data_o;
    logic          err_o;
    logic          v_o;
    logic          ready_and_i;
    logic [AW-1:0] m_axil_awaddr_o;
    logic [2:0]    m_axil_awprot_o;
    logic          m_axil_awvalid_o;
    logic          m_axil_awready_i;
    logic [DW-1:0] m_axil_wdata_o;
    logic [MW-1:0] m_axil_wstrb_o;
    logic          m_axil_wvalid_o;
    logic          m_axil_wready_i;
    logic [1:0]    m_axil_bresp_i;
    logic          m_axil_bvalid_i;
    logic          m_axil_bready_o;
    logic [AW-1:0] m_axil_araddr_o;
    logic [2:0]    m_axil_arprot_o;
    logic          m_axil_arvalid_o;
    logic          m_axil_arready_i;
    logic [DW-1:0] m_axil_rdata_i;
    logic [1:0]    m_axil_rresp_i;
    logic          m_axil_rvalid_i;
    logic          m_axil_rready_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    eth_axil_fifo_initiator #(
        .axil_data_width_p(DW),
        .axil_addr_width_p(AW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .addr_i(addr_i), .data_i(data_i), .w_i(w_i), .wmask_i(wmask_i),
        .v_i(v_i), .ready_and_o(ready_and_o),
        .data_o(data_o), .err_o(err_o), .v_o(v_o), .ready_and_i(ready_and_i),
        .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o),
        .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
        .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
        .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
        .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i),
        .m_axil_bready_o(m_axil_bready_o),
        .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arprot_o(m_axil_arprot_o),
        .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
        .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i),
        .m_axil_rvalid_i(m_axil_rvalid_i), .m_axil_rready_o(m_axil_rready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, " awvalid"}, 64'(m_axil_awvalid_o), 64'd0);
        chk({tag, " wvalid"},  64'(m_axil_wvalid_o),  64'd0);
        chk({tag, " arvalid"}, 64'(m_axil_arvalid_o), 64'd0);
        chk({tag, " bready"},  64'(m_axil_bready_o),  64'd0);
        chk({tag, " rready"},  64'(m_axil_rready_o),  64'd0);
        chk({tag, " v_o"},     64'(v_o),              64'd0);
    endtask

    // One transaction end-to-end. d1/d2: AW/W (or AR/unused) ready delays after valid rises,
    // d3: B (or R) valid delay after ready rises, cd: cycles v_o waits before ready_and_i.
    // The model is a timeline: handshakes fall on cycles derived from the delays, and every
    // output is checked every cycle against that timeline.
    task automatic run_txn(input bit w, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [MW-1:0] mask, input int d1, input int d2, input int d3,
                           input logic [1:0] resp, input logic [DW-1:0] rdata, input int cd);
        int a_hs, w_hs, s0, s1, v0, v1;
        logic [DW-1:0] exp_data;
        a_hs = 1 + d1;
        w_hs = w ? 1 + d2 : 0;
        s0   = (w && w_hs > a_hs) ? w_hs + 1 : a_hs + 1;
        s1   = s0 + d3;
        v0   = s1 + 1;
        v1   = v0 + cd;
        exp_data = w ? '0 : rdata;
        for (int c = 0; c <= v1; c++) begin
            @(negedge clk_i);
            chk($sformatf("ready_and_o c%0d", c), 64'(ready_and_o), 64'(c == 0));
            chk($sformatf("awvalid c%0d", c), 64'(m_axil_awvalid_o), 64'(w && c >= 1 && c <= a_hs));
            chk($sformatf("wvalid c%0d", c),  64'(m_axil_wvalid_o),  64'(w && c >= 1 && c <= w_hs));
            chk($sformatf("arvalid c%0d", c), 64'(m_axil_arvalid_o), 64'(!w && c >= 1 && c <= a_hs));
            chk($sformatf("bready c%0d", c),  64'(m_axil_bready_o),  64'(w && c >= s0 && c <= s1));
            chk($sformatf("rready c%0d", c),  64'(m_axil_rready_o),  64'(!w && c >= s0 && c <= s1));
            chk($sformatf("v_o c%0d", c),     64'(v_o),              64'(c >= v0 && c <= v1));
            if (m_axil_awvalid_o) begin
                chk("awaddr", 64'(m_axil_awaddr_o), 64'(addr));
                chk("awprot", 64'(m_axil_awprot_o), 64'd0);
            end
            if (m_axil_wvalid_o) begin
                chk("wdata", 64'(m_axil_wdata_o), 64'(data));
                chk("wstrb", 64'(m_axil_wstrb_o), 64'(mask));
            end
            if (m_axil_arvalid_o) begin
                chk("araddr", 64'(m_axil_araddr_o), 64'(addr));
                chk("arprot", 64'(m_axil_arprot_o), 64'd0);
            end
            if (c >= v0 && c <= v1) begin
                chk($sformatf("data_o c%0d", c), 64'(data_o), 64'(exp_data));
                chk($sformatf("err_o c%0d", c),  64'(err_o),  64'(resp != 2'b00));
            end
            // Request side: the real request at cycle 0, random noise afterwards.
            if (c == 0) begin
                v_i = 1'b1; w_i = w; addr_i = addr; data_i = data; wmask_i = mask;
            end else begin
                v_i = 1'($urandom); w_i = 1'($urandom); addr_i = $urandom;
                data_i = DW'($urandom); wmask_i = MW'($urandom);
            end
            // Slave side: readies low until the scheduled handshake, noise after it.
            m_axil_awready_i = (c == a_hs) ? 1'b1 : (c > a_hs ? 1'($urandom) : 1'b0);
            m_axil_arready_i = m_axil_awready_i;
            if (w) m_axil_wready_i = (c == w_hs) ? 1'b1 : (c > w_hs ? 1'($urandom) : 1'b0);
            else   m_axil_wready_i = 1'($urandom);
            if (w) begin
                m_axil_bvalid_i = (c == s1) ? 1'b1 : ((c < s0 || c > s1) ? 1'($urandom) : 1'b0);
                m_axil_rvalid_i = 1'($urandom);
            end else begin
                m_axil_rvalid_i = (c == s1) ? 1'b1 : ((c < s0 || c > s1) ? 1'($urandom) : 1'b0);
                m_axil_bvalid_i = 1'($urandom);
            end
            m_axil_bresp_i = (c == s1) ? resp : 2'($urandom);
            m_axil_rresp_i = (c == s1) ? resp : 2'($urandom);
            m_axil_rdata_i = (c == s1) ? rdata : DW'($urandom);
            if (c < v0)       ready_and_i = 1'($urandom);
            else if (c < v1)  ready_and_i = 1'b0;
            else              ready_and_i = 1'b1;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; wmask_i = '0; ready_and_i = 1'b0;
        m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0; m_axil_arready_i = 1'b0;
        m_axil_bresp_i = 2'b00; m_axil_bvalid_i = 1'b0;
        m_axil_rdata_i = '0; m_axil_rresp_i = 2'b00; m_axil_rvalid_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_quiet("reset");
        chk("reset ready_and_o", 64'(ready_and_o), 64'd0);
        chk("reset data_o", 64'(data_o), 64'd0);
        chk("reset err_o", 64'(err_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post-reset ready_and_o", 64'(ready_and_o), 64'd1);

        // Minimum-latency write, all slaves ready
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
        // Read with arready held off 3 cycles
        run_txn(1'b0, 32'h20, 32'h0, 4'h0, 3, 0, 0, 2'b00, 32'h12345678, 0);
        // Write with W accepted 2 cycles after AW
        run_txn(1'b1, 32'h44, 32'hCAFEF00D, 4'h5, 0, 2, 1, 2'b00, 32'h0, 0);
        // Erroring read whose response is stalled 5 cycles
        run_txn(1'b0, 32'h88, 32'h0, 4'h0, 0, 0, 2, 2'b10, 32'hA5A5_0F0F, 5);
        // AW late, W early; erroring write
        run_txn(1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'h8, 3, 0, 0, 2'b10, 32'h0, 1);

        // Reset during WRESP abandons the write
        @(negedge clk_i);
        chk("rst-txn ready_and_o", 64'(ready_and_o), 64'd1);
        v_i = 1'b1; w_i = 1'b1; addr_i = 32'h30; data_i = 32'h1111_2222; wmask_i = 4'h3;
        m_axil_awready_i = 1'b1; m_axil_wready_i = 1'b1; m_axil_bvalid_i = 1'b0;
        m_axil_rvalid_i = 1'b0; ready_and_i = 1'b1;
        @(negedge clk_i);
        chk("rst-txn awvalid", 64'(m_axil_awvalid_o), 64'd1);
        chk("rst-txn wvalid", 64'(m_axil_wvalid_o), 64'd1);
        v_i = 1'b0;
        @(negedge clk_i);
        chk("rst-txn bready", 64'(m_axil_bready_o), 64'd1);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk_all_quiet("mid-reset");
        chk("mid-reset ready_and_o", 64'(ready_and_o), 64'd0);
        reset_i = 1'b0;
        m_axil_bvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("after-reset ready_and_o %0d", i), 64'(ready_and_o), 64'd1);
            chk($sformatf("after-reset v_o %0d", i), 64'(v_o), 64'd0);
            chk($sformatf("after-reset bready %0d", i), 64'(m_axil_bready_o), 64'd0);
        end
        m_axil_bvalid_i = 1'b0;
        run_txn(1'b1, 32'h34, 32'h3333_4444, 4'hC, 0, 0, 0, 2'b00, 32'h0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            bit wr;
            wr = 1'($urandom);
            run_txn(wr, $urandom, $urandom, MW'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom),
                    $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_axil_fifo_initiator.md
ETH_AXIL_FIFO_INITIATOR -- requirements
Module: eth_axil_fifo_initiator

Interface
REQ-001 Parameter axil_data_width_p, default 32, AXI4-Lite data width (32 or 64) SHALL be provided.
REQ-002 Parameter axil_addr_width_p, default 32, AXI4-Lite address width SHALL be provided.
REQ-003 Localparam axil_mask_width_lp = axil_data_width_p>>3, the write strobe width, SHALL be derived.
REQ-004 clk_i  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 Request ports SHALL be: addr_i in axil_addr_width_p; data_i in axil_data_width_p; w_i in 1 (1=write); wmask_i in axil_mask_width_lp; v_i in 1; ready_and_o out 1.
REQ-007 Response ports SHALL be: data_o out axil_data_width_p; err_o out 1 (non-OKAY resp); v_o out 1; ready_and_i in 1.
REQ-008 Master write-address ports SHALL be m_axil_awaddr_o (addr width), m_axil_awprot_o (3), m_axil_awvalid_o (1), m_axil_awready_i (1).
REQ-009 Master write-data ports SHALL be m_axil_wdata_o (data width), m_axil_wstrb_o (mask width), m_axil_wvalid_o (1), m_axil_wready_i (1).
REQ-010 Master write-response ports SHALL be m_axil_bresp_i (2), m_axil_bvalid_i (1), m_axil_bready_o (1).
REQ-011 Master read ports SHALL be m_axil_araddr_o, m_axil_arprot_o (3), m_axil_arvalid_o, m_axil_arready_i, m_axil_rdata_i, m_axil_rresp_i (2), m_axil_rvalid_i, m_axil_rready_o.

Function
REQ-012 One transaction outstanding; FSM states IDLE, WRITE, WRESP, READ, RDATA, RESP.
REQ-013 ready_and_o SHALL be 1 only in IDLE; request accepted on v_i & ready_and_o, capturing addr/data/w/wmask into registers.
REQ-014 IDLE -> WRITE on accepted write; IDLE -> READ on accepted read; valids appear the cycle after acceptance.
REQ-015 In WRITE, awvalid and wvalid SHALL both assert on entry and each deassert independently the cycle after its own handshake; same-cycle handshakes allowed.
REQ-016 WRITE -> WRESP once both AW and W handshakes have completed; bready SHALL be 1 only in WRESP.
REQ-017 WRESP -> RESP on bvalid; data_o = 0, err_o = (bresp != 2'b00).
REQ-018 In READ, arvalid = 1; READ -> RDATA on arready; rready SHALL be 1 only in RDATA.
REQ-019 RDATA -> RESP on rvalid; data_o = rdata, err_o = (rresp != 2'b00).
REQ-020 In RESP, v_o = 1 with data_o/err_o stable; RESP -> IDLE on ready_and_i.
REQ-021 Asserted valids SHALL remain asserted with stable payload until handshake (AXI rule), irrespective of ready_and_i.
REQ-022 awaddr/araddr = captured addr unmodified; wstrb = captured wmask; wdata = captured data; awprot/arprot = 3'b000.
REQ-023 Minimum latency: write accept cycle 0, AW/W cycle 1, bvalid cycle 2, v_o cycle 3; read identical.
REQ-024 bvalid/rvalid outside WRESP/RDATA SHALL be ignored (no state change).

Reset
REQ-025 During reset: state IDLE, all valid/ready outputs 0 except ready_and_o (0 during reset, 1 the cycle after release), data_o 0, err_o 0.
REQ-026 Reset mid-transaction SHALL abandon it; no response SHALL be issued for it.

Structure
REQ-027 The state enum and AXI resp constants (OKAY 2'b00, SLVERR 2'b10) SHALL reside in a shared package eth_axil_pkg.
REQ-028 No sub-module is required; one FSM plus payload/response registers.

Verification
REQ-029 Write addr 0x10, data 0xDEADBEEF, wmask 0xF, slave ready always, bresp 0 -> awaddr 0x10, wstrb 0xF, v_o cycle 3, data_o 0, err_o 0.
REQ-030 Read addr 0x20, arready delayed 3 cycles, rdata 0x12345678 -> arvalid held 4 cycles, data_o 0x12345678, err_o 0.
REQ-031 Write with wready 2 cycles after awready -> awvalid drops after AW handshake, wvalid held, bready asserted only after W handshake.
REQ-032 Read with rresp 2'b10 -> err_o 1; ready_and_i low 5 cycles -> v_o/data_o held, ready_and_o 0 until consumed.
REQ-033 reset_i pulsed during WRESP -> all valids 0 next cycle, no v_o, next write completes normally.
